decoder_2to4_buf: RTL and testbench

DECODER_2TO4_BUF -- requirements
Module: decoder_2to4_buf

---
 rtl/dec_pkg.sv | 23 ++
 rtl/decoder_2to4_core.sv | 19 +
 rtl/decoder_2to4_buf.sv | 129 ++++++++++++
 tb/tb_decoder_2to4_buf.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared definitions for the 2-to-4 decoder with a two-entry output buffer:
// buffer state encoding, decode width and the one-hot helper.
package dec_pkg;

  localparam int DEC_W = 4;
  localparam int A_W   = 2;

  // Buffer occupancy: EMPTY holds nothing, ONE holds the output register,
  // FULL holds both the output register and the skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // One-hot word with bit 'code' set.
  function automatic logic [DEC_W-1:0] onehot(input logic [A_W-1:0] code);
    logic [DEC_W-1:0] base;
    base = {{(DEC_W-1){1'b0}}, 1'b1};
    return base << code;
  endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// Purely combinational 2-to-4 decode. A disabled decode yields the null
// word, which is still a real word as far as the buffer is concerned.
module decoder_2to4_core
  import dec_pkg::*;
(
  input  logic [A_W-1:0]   a_i,
  input  logic             en_i,
  output logic [DEC_W-1:0] y_o
);

  // Decode a into a one-hot word, or all zeros when disabled.
  always_comb begin
    y_o = '0;
    if (en_i) begin
      y_o = onehot(a_i);
    end
  end

endmodule

// File: rtl/decoder_2to4_buf.sv
// 2-to-4 decoder feeding a two-entry buffer (output register + skid
// register) with per-output hit counters.
//
// Handshake: a word moves on the input side on any cycle with
// in_valid && in_ready, and on the output side on any cycle with
// out_valid && out_ready. in_ready and out_valid are registers, so neither
// side depends combinationally on the other; in_ready drops only once both
// entries are occupied, which is why the skid register exists.
module decoder_2to4_buf
  import dec_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [A_W-1:0]     a,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DEC_W-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               clr_cnt,
  output logic [4*CNT_W-1:0] hit_cnt,
  output state_t             dbg_state_o
);

  state_t                       state_q;
  logic [DEC_W-1:0]             out_q;
  logic [DEC_W-1:0]             skid_q;
  logic                         out_valid_q;
  logic                         in_ready_q;
  logic [DEC_W-1:0][CNT_W-1:0]  cnt_q;
  logic [DEC_W-1:0][CNT_W-1:0]  cnt_d;
  logic [DEC_W-1:0]             dec_word;
  logic                         accept;
  logic                         xfer;

  decoder_2to4_core u_core (
    .a_i  (a),
    .en_i (en),
    .y_o  (dec_word)
  );

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid_q && out_ready;

  // Buffer FSM: tracks occupancy and moves words between input, skid and
  // output register; ready/valid flags are registered alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            out_q       <= dec_word;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            out_q <= dec_word;
          end else if (accept) begin
            skid_q     <= dec_word;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (xfer) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (xfer) begin
            out_q      <= skid_q;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_q       <= '0;
          skid_q      <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Next counter values: saturating increment per set bit of a transferred
  // word; a clear wins over any same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (xfer) begin
      for (int i = 0; i < DEC_W; i++) begin
        if (out_q[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Hit counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign y           = out_q;
  assign hit_cnt     = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_decoder_2to4_buf.sv
// Bench for decoder_2to4_buf: reference model is a queue of expected words
// (at most two outstanding) plus integer hit counters.
module tb_decoder_2to4_buf;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         a;
  logic               en;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         y;
  logic               out_valid;
  logic               out_ready;
  logic               clr_cnt;
  logic [4*CNT_W-1:0] hit_cnt;
  logic [1:0]         dbg_state;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  int         m_cnt[4];
  bit         m_live;

  decoder_2to4_buf #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .y           (y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clr_cnt     (clr_cnt),
    .hit_cnt     (hit_cnt),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset-value block
  always #5 clk = ~clk;

  // Reference model views
  function automatic logic [3:0] word_of(input logic [1:0] av, input logic env);
    if (!env) return 4'b0000;
    return 4'(2 ** av);
  endfunction

  function automatic logic [3:0] m_y();
    return (exp_q.size() > 0) ? exp_q[0] : 4'b0000;
  endfunction

  function automatic logic m_valid();
    return exp_q.size() > 0;
  endfunction

  function automatic logic m_ready();
    return m_live && (exp_q.size() < 2);
  endfunction

  function automatic logic [1:0] m_occ();
    return 2'(exp_q.size());
  endfunction

  function automatic logic [4*CNT_W-1:0] m_hit();
    logic [4*CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    return r;
  endfunction

  // Driver: apply one cycle of inputs (called at a negedge), advance the
  // model across the posedge, return at the following negedge.
  task automatic drive_cycle(input logic vld, input logic [1:0] av, input logic env,
                             input logic ordy, input logic clr, input logic rstn);
    bit acc, xf;
    logic [3:0] head;
    in_valid  = vld;
    a         = av;
    en        = env;
    out_ready = ordy;
    clr_cnt   = clr;
    rst_n     = rstn;
    acc = vld && m_ready();
    xf  = m_valid() && ordy;
    @(posedge clk);
    if (!rstn) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_live = 0;
    end else begin
      if (xf) begin
        head = exp_q.pop_front();
        for (int i = 0; i < 4; i++)
          if (head[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
      end
      if (acc) exp_q.push_back(word_of(av, env));
      if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_live = 1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({out_valid, y, in_ready} !== 6'b0_0000_0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b y=%b ready=%b expected 0 0000 0", out_valid, y, in_ready);
    end
    checks++;
    if (hit_cnt !== '0) begin
      errors++;
      $display("FAIL reset_hit_cnt: got %h expected 0", hit_cnt);
    end
    drive_cycle(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    drain();
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 2'(k), 1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({y, out_valid, in_ready, dbg_state} !== {4'(1 << k), 1'b1, 1'b1, 2'd1}) begin
        errors++;
        $display("FAIL stream_%0d: got y=%b v=%b r=%b st=%0d expected y=%b v=1 r=1 st=1",
                 k, y, out_valid, in_ready, dbg_state, 4'(1 << k));
      end
    end
    drive_cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (hit_cnt !== m_hit()) begin
      errors++;
      $display("FAIL stream_hits: got %h expected %h", hit_cnt, m_hit());
    end
  endtask

  task automatic test_backpressure();
    drain();
    drive_cycle(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({y, in_ready, dbg_state} !== {4'b0100, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL bp_first: got y=%b r=%b st=%0d expected 0100 1 1", y, in_ready, dbg_state);
    end
    drive_cycle(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({y, in_ready, dbg_state} !== {4'b0100, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL bp_full: got y=%b r=%b st=%0d expected 0100 0 2", y, in_ready, dbg_state);
    end
    drive_cycle(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({y, out_valid, in_ready} !== {4'b0100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bp_hold: got y=%b v=%b r=%b expected 0100 1 0", y, out_valid, in_ready);
    end
    drive_cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({y, out_valid, dbg_state} !== {4'b1000, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL bp_second: got y=%b v=%b st=%0d expected 1000 1 1", y, out_valid, dbg_state);
    end
    drive_cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({y, out_valid, hit_cnt} !== {4'b0000, 1'b0, m_hit()}) begin
      errors++;
      $display("FAIL bp_done: got y=%b v=%b hits=%h expected 0000 0 %h", y, out_valid, hit_cnt, m_hit());
    end
  endtask

  task automatic test_enable_off();
    logic [4*CNT_W-1:0] snap;
    drain();
    snap = m_hit();
    drive_cycle(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({y, out_valid} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL en_off_word: got y=%b v=%b expected 0000 1", y, out_valid);
    end
    drive_cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({out_valid, hit_cnt} !== {1'b0, snap}) begin
      errors++;
      $display("FAIL en_off_after: got v=%b hits=%h expected 0 %h", out_valid, hit_cnt, snap);
    end
  endtask

  task automatic test_counters();
    drive_cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (hit_cnt !== '0) begin
      errors++;
      $display("FAIL cnt_clear: got %h expected 0", hit_cnt);
    end
    for (int k = 0; k < 5; k++) drive_cycle(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (hit_cnt[1*CNT_W +: CNT_W] !== CNT_W'(3)) begin
      errors++;
      $display("FAIL cnt_saturate: got %0d expected 3", hit_cnt[1*CNT_W +: CNT_W]);
    end
    drive_cycle(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({out_valid, hit_cnt} !== {1'b0, {(4*CNT_W){1'b0}}}) begin
      errors++;
      $display("FAIL cnt_clr_wins: got v=%b hits=%h expected 0 0", out_valid, hit_cnt);
    end
  endtask

  task automatic test_random();
    logic vld, env, ordy, clr;
    logic [1:0] av;
    for (int n = 0; n < 400; n++) begin
      vld  = 1'($urandom_range(0, 1));
      av   = 2'($urandom_range(0, 3));
      env  = ($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 31) == 0);
      drive_cycle(vld, av, env, ordy, clr, 1'b1);
      checks++;
      if ({out_valid, y, in_ready, dbg_state, hit_cnt} !== {m_valid(), m_y(), m_ready(), m_occ(), m_hit()}) begin
        errors++;
        $display("FAIL random_%0d: got v=%b y=%b r=%b st=%0d hits=%h expected v=%b y=%b r=%b st=%0d hits=%h",
                 n, out_valid, y, in_ready, dbg_state, hit_cnt,
                 m_valid(), m_y(), m_ready(), m_occ(), m_hit());
      end
    end
  endtask

  task automatic test_mid_reset();
    drain();
    drive_cycle(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL midrst_full: got st=%0d expected 2", dbg_state);
    end
    drive_cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({out_valid, y, in_ready, hit_cnt} !== {1'b0, 4'b0000, 1'b0, {(4*CNT_W){1'b0}}}) begin
      errors++;
      $display("FAIL midrst_cleared: got v=%b y=%b r=%b hits=%h expected 0 0000 0 0", out_valid, y, in_ready, hit_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({out_valid, y} !== 5'b0_0000) begin
        errors++;
        $display("FAIL midrst_after_%0d: got v=%b y=%b expected 0 0000", k, out_valid, y);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; a = 2'd0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    m_live = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_enable_off();
    test_counters();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
